// File: rtl/interim_write_scheduler_pkg.sv
// Shared types and defaults for the interim buffer write scheduler.
// Holds the FSM encoding and the grant index width helper.
package interim_write_scheduler_pkg;

    localparam int NUM_REQ_D  = 4;
    localparam int ADDR_LEN_D = 6;
    localparam int DATA_LEN_D = 32;
    localparam int CNT_LEN_D  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interim_write_scheduler_if.sv
// Producer-side and buffer-side signals of the write scheduler.
// The scheduler uses the slave view, its environment the master view.
interface interim_write_scheduler_if
    import interim_write_scheduler_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_D,
    parameter int addrLen = ADDR_LEN_D,
    parameter int dataLen = DATA_LEN_D,
    parameter int cntLen  = CNT_LEN_D
);
    localparam int IdW = id_width(NUM_REQ);

    logic                       cfg_start;
    logic [cntLen-1:0]          cfg_wr_count;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*addrLen-1:0] req_addr;
    logic [NUM_REQ*dataLen-1:0] req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       wrt_en;
    logic [addrLen-1:0]         wrt_addr;
    logic [dataLen-1:0]         wrt_data;
    logic [IdW-1:0]             grant_id;
    logic                       busy;
    logic                       done;

    modport master (
        output cfg_start, cfg_wr_count,
        output req_valid, req_addr, req_data,
        input  req_ready, wrt_en, wrt_addr,
        input  wrt_data, grant_id, busy, done
    );

    modport slave (
        input  cfg_start, cfg_wr_count,
        input  req_valid, req_addr, req_data,
        output req_ready, wrt_en, wrt_addr,
        output wrt_data, grant_id, busy, done
    );

endinterface

// File: rtl/interim_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr,
// wrapping modulo NUM_REQ; returns one-hot grant and its index.
module rr_arbiter
    import interim_write_scheduler_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_D,
    localparam int IdW = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IdW-1:0]     idx,
    output logic               any
);

    always_comb begin
        int s;
        logic [IdW-1:0] j;
        s     = 0;
        j     = '0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            s = int'(ptr) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            j = IdW'(s);
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/interim_write_scheduler.sv
// Shares the interim buffer write port among NUM_REQ producers for
// one epoch of cfg_wr_count writes, then pulses done.
module interim_write_scheduler
    import interim_write_scheduler_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_D,
    parameter int addrLen = ADDR_LEN_D,
    parameter int dataLen = DATA_LEN_D,
    parameter int cntLen  = CNT_LEN_D
) (
    input logic clk,
    input logic rst,
    interim_write_scheduler_if.slave bus
);
    localparam int IdW = id_width(NUM_REQ);

    state_t             state, state_n;
    logic [cntLen-1:0]  remaining, remaining_n;
    logic [IdW-1:0]     rr_ptr, rr_ptr_n;
    logic [NUM_REQ-1:0] grant, ready;
    logic [IdW-1:0]     gidx;
    logic               any, accept;
    logic [addrLen-1:0] sel_addr, wr_addr;
    logic [dataLen-1:0] sel_data, wr_data;
    logic [IdW-1:0]     wr_id;
    logic               wr_en;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    assign accept = (state == RUN) && any;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = bus.req_addr[i*addrLen +: addrLen];
                sel_data = bus.req_data[i*dataLen +: dataLen];
            end
        end
    end

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        rr_ptr_n    = rr_ptr;
        ready       = '0;
        unique case (state)
            IDLE: begin
                if (bus.cfg_start) begin
                    if (bus.cfg_wr_count != '0) begin
                        state_n     = RUN;
                        remaining_n = bus.cfg_wr_count;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                ready = grant;
                if (any) begin
                    remaining_n = remaining - cntLen'(1);
                    // pointer moves just past the winner
                    if (gidx == IdW'(NUM_REQ - 1))
                        rr_ptr_n = '0;
                    else
                        rr_ptr_n = gidx + IdW'(1);
                    if (remaining == cntLen'(1))
                        state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            rr_ptr    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_id     <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            rr_ptr    <= rr_ptr_n;
            wr_en     <= accept;
            if (accept) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
                wr_id   <= gidx;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.wrt_en    = wr_en;
    assign bus.wrt_addr  = wr_addr;
    assign bus.wrt_data  = wr_data;
    assign bus.grant_id  = wr_id;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_interim_write_scheduler.sv
// Bench for interim_write_scheduler: a cycle model predicts grants and
// queues expected writes, which are popped when wrt_en is observed.
module tb_interim_write_scheduler;
    import interim_write_scheduler_pkg::*;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int CW = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    id;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    interim_write_scheduler_if #(
        .NUM_REQ(N), .addrLen(AW), .dataLen(DW), .cntLen(CW)
    ) bus ();

    interim_write_scheduler #(
        .NUM_REQ(N), .addrLen(AW), .dataLen(DW), .cntLen(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_t        exp_q[$];
    int         checks, errors;
    state_t     m_st;
    int         m_rem, m_ptr, m_acc;
    int         wr_seen, done_seen, busy_cyc, rdy_seen, cyc, done_wr;
    logic [1:0] gl[$];
    int         ws[$];
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    bit         rand_data;

    task automatic tick();
        logic [N-1:0] er;
        int g;
        wr_t e;
        @(negedge clk);
        er = '0;
        g  = -1;
        if (m_st == RUN)
            for (int k = 0; k < N; k++)
                if (g < 0 && bus.req_valid[(m_ptr + k) % N])
                    g = (m_ptr + k) % N;
        if (g >= 0) er[g] = 1'b1;
        checks++;
        if (bus.req_ready !== er) begin
            errors++;
            $display("FAIL req_ready got %b exp %b cyc %0d",
                     bus.req_ready, er, cyc);
        end
        checks++;
        if (bus.busy !== (m_st != IDLE)) begin
            errors++;
            $display("FAIL busy got %b exp %b cyc %0d",
                     bus.busy, (m_st != IDLE), cyc);
        end
        checks++;
        if (bus.done !== (m_st == DONE)) begin
            errors++;
            $display("FAIL done got %b exp %b cyc %0d",
                     bus.done, (m_st == DONE), cyc);
        end
        checks++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bus.wrt_en !== 1'b1 || bus.wrt_addr !== e.a ||
                bus.wrt_data !== e.d || bus.grant_id !== e.id) begin
                errors++;
                $display("FAIL write got en%b a%h d%h id%0d exp a%h d%h id%0d",
                         bus.wrt_en, bus.wrt_addr, bus.wrt_data,
                         bus.grant_id, e.a, e.d, e.id);
            end
        end else if (bus.wrt_en !== 1'b0) begin
            errors++;
            $display("FAIL wrt_en_idle got %b exp 0 cyc %0d",
                     bus.wrt_en, cyc);
        end
        if (bus.req_ready !== '0) rdy_seen++;
        if (bus.busy === 1'b1) busy_cyc++;
        if (bus.wrt_en === 1'b1) begin
            wr_seen++;
            gl.push_back(bus.grant_id);
            ws.push_back(cyc);
            last_a = bus.wrt_addr;
            last_d = bus.wrt_data;
        end
        if (bus.done === 1'b1) begin
            done_seen++;
            done_wr = (bus.wrt_en === 1'b1) ? wr_seen : -1;
        end
        case (m_st)
            IDLE: if (bus.cfg_start) begin
                if (bus.cfg_wr_count == '0) m_st = DONE;
                else begin
                    m_st  = RUN;
                    m_rem = int'(bus.cfg_wr_count);
                end
            end
            RUN: if (g >= 0) begin
                e.a  = bus.req_addr[g*AW +: AW];
                e.d  = bus.req_data[g*DW +: DW];
                e.id = 2'(g);
                exp_q.push_back(e);
                m_acc++;
                m_rem--;
                m_ptr = (g + 1) % N;
                if (m_rem == 0) m_st = DONE;
            end
            default: m_st = IDLE;
        endcase
        cyc++;
        @(posedge clk);
        #1;
        if (rand_data) begin
            bus.req_addr = 24'($urandom);
            bus.req_data = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic clr();
        wr_seen = 0; done_seen = 0; busy_cyc = 0; rdy_seen = 0;
        done_wr = -1; m_acc = 0;
        gl.delete();
        ws.delete();
    endtask

    task automatic start(input int count);
        bus.cfg_wr_count = CW'(count);
        bus.cfg_start    = 1'b1;
        tick();
        bus.cfg_start    = 1'b0;
    endtask

    task automatic run_until_done(input int bound);
        int n = 0;
        while (done_seen == 0 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (done_seen == 0) begin
            errors++;
            $display("FAIL done_timeout got 0 exp 1 after %0d", bound);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.wrt_en !== 1'b0 ||
            bus.req_ready !== '0) begin
            errors++;
            $display("FAIL async_rst got busy%b en%b rdy%b exp 0",
                     bus.busy, bus.wrt_en, bus.req_ready);
        end
        m_st = IDLE;
        m_ptr = 0;
        m_rem = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n = 0;
        @(negedge clk);
        checks++;
        if (bus.wrt_en !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.req_ready !== '0 ||
            bus.wrt_addr !== '0 || bus.wrt_data !== '0 ||
            bus.grant_id !== '0) begin
            errors++;
            $display("FAIL reset_state got en%b busy%b done%b exp 0",
                     bus.wrt_en, bus.busy, bus.done);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        clr();
        rand_data     = 1'b1;
        bus.req_valid = '1;
        start(5);
        while (wr_seen < 2 && n < 20) begin
            tick();
            n++;
        end
        #2;
        apply_reset();
        clr();
        start(3);
        run_until_done(20);
        tick();
        tick();
        checks++;
        if (wr_seen != 3 || done_seen != 1) begin
            errors++;
            $display("FAIL post_rst_epoch got %0d writes %0d done exp 3 1",
                     wr_seen, done_seen);
        end
    endtask

    task automatic test_fairness();
        apply_reset();
        clr();
        rand_data     = 1'b1;
        bus.req_valid = '1;
        start(8);
        run_until_done(30);
        checks++;
        if (gl.size() != 8) begin
            errors++;
            $display("FAIL fair_count got %0d exp 8", gl.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (gl[i] !== 2'(i % 4)) begin
                    errors++;
                    $display("FAIL fair_grant%0d got %0d exp %0d",
                             i, gl[i], i % 4);
                end
            end
        end
        checks++;
        if (done_wr != 8) begin
            errors++;
            $display("FAIL fair_done_with_last got %0d exp 8", done_wr);
        end
    endtask

    task automatic test_sparse();
        int n = 0;
        rand_data     = 1'b0;
        bus.req_valid = 4'b0100;
        bus.req_addr  = '0;
        bus.req_addr[2*AW +: AW] = 6'h05;
        bus.req_data  = '0;
        bus.req_data[2*DW +: DW] = 32'hA5A5_0001;
        clr();
        start(3);
        bus.req_data[2*DW +: DW] = 32'hA5A5_0001 + 32'(m_acc);
        while (done_seen == 0 && n < 20) begin
            tick();
            bus.req_data[2*DW +: DW] = 32'hA5A5_0001 + 32'(m_acc);
            n++;
        end
        checks++;
        if (wr_seen != 3 || gl.size() != 3) begin
            errors++;
            $display("FAIL sparse_count got %0d exp 3", wr_seen);
        end else begin
            checks++;
            if (gl[0] !== 2'd2 || gl[1] !== 2'd2 || gl[2] !== 2'd2) begin
                errors++;
                $display("FAIL sparse_id got %0d %0d %0d exp 2 2 2",
                         gl[0], gl[1], gl[2]);
            end
            checks++;
            if (ws[2] - ws[0] != 2) begin
                errors++;
                $display("FAIL sparse_consec got span %0d exp 2",
                         ws[2] - ws[0]);
            end
        end
        checks++;
        if (last_a !== 6'h05 || last_d !== 32'hA5A5_0003) begin
            errors++;
            $display("FAIL sparse_last got a%h d%h exp a05 dA5A50003",
                     last_a, last_d);
        end
    endtask

    task automatic test_ptr_skip();
        apply_reset();
        rand_data     = 1'b1;
        bus.req_valid = 4'b0001;
        clr();
        start(1);
        run_until_done(10);
        bus.req_valid = 4'b1001;
        clr();
        start(2);
        run_until_done(10);
        checks++;
        if (gl.size() != 2) begin
            errors++;
            $display("FAIL skip_count got %0d exp 2", gl.size());
        end else if (gl[0] !== 2'd3 || gl[1] !== 2'd0) begin
            errors++;
            $display("FAIL skip_order got %0d %0d exp 3 0", gl[0], gl[1]);
        end
    endtask

    task automatic test_zero();
        bus.req_valid = '1;
        clr();
        start(0);
        tick();
        tick();
        tick();
        checks++;
        if (rdy_seen != 0 || done_seen != 1 || busy_cyc != 1) begin
            errors++;
            $display("FAIL zero_cnt got rdy%0d done%0d busy%0d exp 0 1 1",
                     rdy_seen, done_seen, busy_cyc);
        end
    endtask

    task automatic test_restart();
        bus.req_valid = '1;
        clr();
        start(2);
        bus.cfg_wr_count = CW'(9);
        bus.cfg_start    = 1'b1;
        tick();
        bus.cfg_start    = 1'b0;
        run_until_done(10);
        tick();
        tick();
        tick();
        checks++;
        if (wr_seen != 2 || done_seen != 1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL restart got %0d writes %0d done busy%b exp 2 1 0",
                     wr_seen, done_seen, bus.busy);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        m_st = IDLE; m_rem = 0; m_ptr = 0;
        rand_data = 1'b0;
        clr();
        bus.cfg_start    = 1'b0;
        bus.cfg_wr_count = '0;
        bus.req_valid    = '0;
        bus.req_addr     = '0;
        bus.req_data     = '0;
        test_reset();
        test_fairness();
        test_sparse();
        test_ptr_skip();
        test_zero();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got stuck exp finish");
        $fatal(1, "timeout");
    end

endmodule
